int_commit_receiver: RTL

//  Receive end of the Int write-back commit interface, inside RS Int.

---
 rtl/int_commit_receiver_pkg.sv | 25 ++
 rtl/int_commit_receiver_commit_fifo.sv | 73 +++++++
 rtl/int_commit_receiver.sv | 99 +++++++++
 3 files changed

// File: rtl/int_commit_receiver_pkg.sv
// +--------------------------------------------------------------------+
// | int_commit_receiver_pkg                                            |
// | Shared constants and entry layout for the Int write-back commit.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package int_commit_receiver_pkg;

   localparam int COMMIT_FIFO_DEPTH_LOG2 = 2;
   localparam int RS_ADDR_W_DEF          = 3;
   localparam int EXC_W_DEF              = 4;
   localparam int DATA_W_DEF             = 32;

   localparam logic [EXC_W_DEF-1:0] EXC_TYPE_NULL = '0;

   typedef struct packed {
      logic [RS_ADDR_W_DEF-1:0] addr;
      logic [EXC_W_DEF-1:0]     exc;
      logic [DATA_W_DEF-1:0]    data;
   } commit_entry_t;

endpackage

`default_nettype wire

// File: rtl/int_commit_receiver_commit_fifo.sv
// +--------------------------------------------------------------------+
// | commit_fifo                                                        |
// | Generic synchronous FIFO, count-based full/empty, combinational    |
// | head (zero when empty), registered free-slot credit.               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module commit_fifo
   import int_commit_receiver_pkg::*;
#(
   parameter int WIDTH      = 39,
   parameter int DEPTH_LOG2 = COMMIT_FIFO_DEPTH_LOG2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      head,
   output logic                  valid,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic [DEPTH_LOG2:0]   free
);

   localparam int c_depth = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] c_depth_cnt = (DEPTH_LOG2 + 1)'(c_depth);

   logic [WIDTH-1:0]      r_mem [c_depth];
   logic [DEPTH_LOG2-1:0] r_head;
   logic [DEPTH_LOG2-1:0] r_tail;
   logic [DEPTH_LOG2:0]   r_count;
   logic [DEPTH_LOG2:0]   r_free;

   logic                  w_pop_ok;
   logic                  w_push_ok;
   logic [DEPTH_LOG2:0]   w_count_nxt;

   // A push into a full FIFO is only accepted when the head leaves this cycle.
   assign w_pop_ok    = pop && (r_count != '0);
   assign w_push_ok   = push && ((r_count != c_depth_cnt) || w_pop_ok);
   assign w_count_nxt = r_count + {{DEPTH_LOG2{1'b0}}, w_push_ok}
                                - {{DEPTH_LOG2{1'b0}}, w_pop_ok};

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_free  <= c_depth_cnt;
      end else begin
         if (w_push_ok) r_tail <= r_tail + 1'b1;
         if (w_pop_ok)  r_head <= r_head + 1'b1;
         r_count <= w_count_nxt;
         r_free  <= c_depth_cnt - w_count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && !clear && w_push_ok) r_mem[r_tail] <= din;
   end

   assign valid = (r_count != '0);
   assign full  = (r_count == c_depth_cnt);
   assign count = r_count;
   assign free  = r_free;
   assign head  = valid ? r_mem[r_head] : '0;

endmodule

`default_nettype wire

// File: rtl/int_commit_receiver.sv
// +--------------------------------------------------------------------+
// | int_commit_receiver                                                |
// | Int WB commit receiver: done flags, commit FIFO, ROB drain port.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module int_commit_receiver
   import int_commit_receiver_pkg::*;
#(
   parameter int RS_ADDR_W  = RS_ADDR_W_DEF,
   parameter int EXC_W      = EXC_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int DEPTH_LOG2 = COMMIT_FIFO_DEPTH_LOG2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    commit_en,
   input  logic [RS_ADDR_W-1:0]    commit_addr,
   input  logic [EXC_W-1:0]        commit_exc_type,
   input  logic [DATA_W-1:0]       commit_data,
   input  logic                    release_en,
   input  logic [RS_ADDR_W-1:0]    release_addr,
   input  logic                    flush,
   output logic [2**RS_ADDR_W-1:0] done_mask,
   output logic                    rob_valid,
   input  logic                    rob_ready,
   output logic [RS_ADDR_W-1:0]    rob_rs_addr,
   output logic [EXC_W-1:0]        rob_exc_type,
   output logic                    rob_is_exc,
   output logic [DATA_W-1:0]       rob_data,
   output logic [DEPTH_LOG2:0]     free_slots,
   output logic                    overflow
);

   localparam int c_entry_w = RS_ADDR_W + EXC_W + DATA_W;
   localparam int c_rs_n    = 2 ** RS_ADDR_W;

   logic [c_entry_w-1:0]  w_push_entry;
   logic [c_entry_w-1:0]  w_head_entry;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic [DEPTH_LOG2:0]   w_count;
   logic [c_rs_n-1:0]     w_set_vec;
   logic [c_rs_n-1:0]     w_clr_vec;
   logic [c_rs_n-1:0]     r_done_mask;
   logic                  r_overflow;

   assign w_push_entry = {commit_addr, commit_exc_type, commit_data};
   assign w_push       = commit_en && !flush;
   assign w_pop        = rob_valid && rob_ready;

   commit_fifo #(
      .WIDTH      (c_entry_w),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_commit_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (flush),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_push_entry),
      .head  (w_head_entry),
      .valid (rob_valid),
      .full  (w_full),
      .count (w_count),
      .free  (free_slots)
   );

   assign w_set_vec = commit_en  ? (c_rs_n'(1) << commit_addr)  : '0;
   assign w_clr_vec = release_en ? (c_rs_n'(1) << release_addr) : '0;

   // Set is applied after clear so a same-entry commit/release keeps the flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_done_mask <= '0;
         r_overflow  <= 1'b0;
      end else if (flush) begin
         r_done_mask <= '0;
      end else begin
         r_done_mask <= (r_done_mask & ~w_clr_vec) | w_set_vec;
         if (commit_en && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   assign done_mask    = r_done_mask;
   assign overflow     = r_overflow;
   assign rob_rs_addr  = w_head_entry[c_entry_w-1 -: RS_ADDR_W];
   assign rob_exc_type = w_head_entry[DATA_W +: EXC_W];
   assign rob_data     = w_head_entry[DATA_W-1:0];
   assign rob_is_exc   = (rob_exc_type != EXC_W'(EXC_TYPE_NULL));

   logic w_unused;
   assign w_unused = ^w_count;

endmodule

`default_nettype wire
